// File: rtl/lsu_subword.sv
// lsu_subword: byte/halfword/word load-store unit with read-modify-write sub-word stores and sticky fault capture
module lsu_subword #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);
   typedef enum logic {IDLE, WRITE} state_t;
   state_t state, state_nx;
   logic [31:0] merge_q, lane_mask, lane_data;
   logic [ADDR_W-1:0] addr_q, word_addr;
   logic is_b, is_h, is_w, bad_f3, misal, legal;
   logic [4:0] sh;
   logic [7:0] byte_v;
   logic [15:0] half_v;
   assign is_b = funct3[1:0] == 2'd0;
   assign is_h = funct3[1:0] == 2'd1;
   assign is_w = funct3[1:0] == 2'd2;
   assign bad_f3 = req_we ? funct3 > 3'd2 : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
   assign misal = (is_h && addr[0]) || (is_w && addr[1:0] != 2'b00);
   assign legal = !bad_f3 && !misal;
   assign word_addr = {addr[ADDR_W-1:2], 2'b00};
   assign sh = {addr[1:0], 3'b000};
   assign byte_v = 8'(mem_rd >> sh);
   assign half_v = 16'(mem_rd >> {addr[1], 4'b0000});
   assign lane_mask = (is_b ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
   assign lane_data = (is_b ? {24'd0, wdata[7:0]} : {16'd0, wdata[15:0]}) << sh;
   // State register; reset cancels any pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // Next state, memory control and load extraction; mem_we/stall are held low while in reset
   always_comb begin
      state_nx = state;
      stall = 1'b0;
      mem_we = 1'b0;
      mem_addr = word_addr;
      mem_wd = wdata;
      rdata = 32'd0;
      if (state == WRITE) begin
         state_nx = IDLE;
         mem_we = rst_n;
         mem_addr = addr_q;
         mem_wd = merge_q;
      end else if (req_valid && legal) begin
         if (req_we) begin
            mem_we = is_w && rst_n;
            stall = !is_w && rst_n;
            state_nx = is_w ? IDLE : WRITE;
         end else begin
            rdata = is_w ? mem_rd :
                    is_h ? {{16{~funct3[2] & half_v[15]}}, half_v} :
                           {{24{~funct3[2] & byte_v[7]}}, byte_v};
         end
      end
   end
   // Capture merged word and its address when a sub-word store enters the write cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         merge_q <= 32'd0;
         addr_q <= '0;
      end else if (state == IDLE && state_nx == WRITE) begin
         merge_q <= (mem_rd & ~lane_mask) | lane_data;
         addr_q <= word_addr;
      end
   end
   // Sticky fault: only the first illegal access records its address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 1'b0;
         fault_addr <= '0;
      end else if (state == IDLE && req_valid && !legal && !fault) begin
         fault <= 1'b1;
         fault_addr <= addr;
      end
   end
endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: randomized check of lsu_subword against a byte-level reference model of loads, stores and faults
module tb_lsu_subword;
   logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
   logic [2:0] funct3 = 3'd0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [31:0] rdata, fault_addr, mem_addr, mem_wd, mem_rd;
   logic stall, fault, mem_we;
   logic [31:0] mem [256] = '{default: 32'd0};
   logic [31:0] ref_mem [256];
   logic m_fault = 1'b0;
   logic [31:0] m_fault_addr = 32'd0;
   int checks = 0, errors = 0;

   lsu_subword #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
      .fault_addr(fault_addr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;
   assign mem_rd = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ok_access(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      if (we ? f3 > 2 : (f3 == 3 || f3 >= 6)) return 1'b0;
      return (a % 32'(sz)) == 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      if (f3 == 0) return b >= 128 ? b + 32'hFFFF_FF00 : b;
      if (f3 == 1) return h >= 32768 ? h + 32'hFFFF_0000 : h;
      if (f3 == 4) return b;
      if (f3 == 5) return h;
      return w;
   endfunction

   function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w, input logic [31:0] wd);
      logic [31:0] mask;
      int k;
      if (f3 == 2) return wd;
      mask = (f3 == 0) ? 32'hFF : 32'hFFFF;
      k = 8 * a[1:0];
      return w - (((w >> k) & mask) << k) + ((wd & mask) << k);
   endfunction

   task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      logic ok, sub;
      logic [31:0] word, nw;
      ok = ok_access(we, f3, a);
      sub = we && ok && f3 != 2;
      word = ref_mem[a[9:2]];
      nw = ref_store(f3, a, word, wd);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      chk("stall", 32'(stall), 32'(sub));
      chk("mem_we", 32'(mem_we), 32'(we && ok && f3 == 2));
      if (!we) chk("rdata", rdata, ok ? ref_load(f3, a, word) : 32'd0);
      if (ok) chk("mem_addr", mem_addr, a & ~32'd3);
      if (we && ok && f3 == 2) chk("sw_wd", mem_wd, wd);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault_addr", fault_addr, m_fault_addr);
      @(posedge clk) #1;
      if (!ok && !m_fault) begin
         m_fault = 1'b1;
         m_fault_addr = a;
      end
      if (sub) begin
         req_valid = 1'($urandom); req_we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
         @(negedge clk);
         chk("wr_we", 32'(mem_we), 32'd1);
         chk("wr_wd", mem_wd, nw);
         chk("wr_addr", mem_addr, a & ~32'd3);
         chk("wr_stall", 32'(stall), 32'd0);
         @(posedge clk) #1;
      end
      if (we && ok) ref_mem[a[9:2]] = nw;
      req_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      req_valid = 1'b0; req_we = 1'b1; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      @(negedge clk);
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_rdata", rdata, 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      @(posedge clk) #1;
   endtask

   initial begin
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_fault_addr", fault_addr, 32'd0);
      rst_n = 1'b1;
      @(posedge clk) #1;
      op(1'b1, 3'd2, 32'h10, 32'h8899AABB);
      op(1'b0, 3'd0, 32'h11, 32'd0);
      op(1'b0, 3'd4, 32'h11, 32'd0);
      op(1'b0, 3'd1, 32'h12, 32'd0);
      op(1'b0, 3'd5, 32'h12, 32'd0);
      op(1'b0, 3'd2, 32'h10, 32'd0);
      op(1'b1, 3'd0, 32'h13, 32'h12345678);
      op(1'b0, 3'd2, 32'h10, 32'd0);
      op(1'b1, 3'd1, 32'h22, 32'h0000CAFE);
      op(1'b1, 3'd2, 32'h24, 32'hDEADBEEF);
      op(1'b0, 3'd2, 32'h20, 32'd0);
      op(1'b0, 3'd2, 32'h26, 32'd0);
      op(1'b1, 3'd1, 32'h31, 32'h0000BEEF);
      op(1'b0, 3'd3, 32'h40, 32'd0);
      op(1'b1, 3'd4, 32'h40, 32'h11111111);
      op(1'b0, 3'd2, 32'h30, 32'd0);
      idle_cycle();
      req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd0; addr = 32'h44; wdata = 32'h000000AB;
      @(negedge clk);
      chk("rmw_stall", 32'(stall), 32'd1);
      @(posedge clk) #1;
      req_valid = 1'b0;
      chk("rmw_wr_we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_we", 32'(mem_we), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_fault", 32'(fault), 32'd0);
      chk("arst_fault_addr", fault_addr, 32'd0);
      m_fault = 1'b0;
      m_fault_addr = 32'd0;
      @(posedge clk) #1;
      rst_n = 1'b1;
      @(posedge clk) #1;
      op(1'b0, 3'd2, 32'h44, 32'd0);
      repeat (400) begin
         if ($urandom_range(0, 9) == 0) idle_cycle();
         else begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0 ? ($urandom & 32'hFFFF_FC00) : 32'd0) | 32'($urandom_range(0, 63));
            op(we, f3, a, $urandom);
         end
      end
      for (int i = 0; i < 256; i++) chk("mem_word", mem[i], ref_mem[i]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
